// File: rtl/axi_stream_source_pkg.sv
// Shared types and helpers for the AXI-Stream source/sink infrastructure.
// Holds FSM state encoding, throttle scale and the pseudo-random step function.
package axi_stream_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam int unsigned PCT_SCALE     = 100;
  localparam logic [31:0] LFSR_FALLBACK = 32'h2545_F491;

  // xorshift32 has no zero-to-nonzero path, so a zero seed is swapped for LFSR_FALLBACK.
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/axi_stream_source_throttle.sv
// Seeded pseudo-random enable: en_out is high on roughly PCT out of PCT_SCALE cycles.
// Reusable by the matching stream sink for TREADY throttling.
module axis_throttle_gen
  import axi_stream_source_pkg::*;
#(
  parameter int unsigned PCT  = 50,
  parameter int unsigned SEED = 1
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);

  localparam logic [31:0] SEED_INIT = (SEED == 0) ? LFSR_FALLBACK : 32'(SEED);
  // Threshold in 16.16 fixed point; PCT >= PCT_SCALE lies above every product, so always enabled.
  localparam logic [31:0] PCT_THR   = (PCT >= PCT_SCALE) ? (32'(PCT_SCALE) << 16)
                                                         : (32'(PCT) << 16);

  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [31:0] prod;

  always_comb begin
    state_d = xorshift32(state_q);
    prod    = {16'b0, state_q[31:16]} * 32'(PCT_SCALE);
    en_out  = (prod < PCT_THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED_INIT;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/axi_stream_source.sv
// AXI-Stream master that emits a run of num_pkts_in packets of pkt_len_in beats each,
// with randomly throttled TVALID, inter-packet gaps and an incrementing payload.
module axi_stream_source
  import axi_stream_source_pkg::*;
#(
  parameter int unsigned             TDATA_WIDTH = 16,
  parameter int unsigned             TID_WIDTH   = 1,
  parameter int unsigned             TDEST_WIDTH = 1,
  parameter int unsigned             TUSER_WIDTH = 1,
  parameter int unsigned             TID_VALUE   = 0,
  parameter int unsigned             TDEST_VALUE = 0,
  parameter logic [TDATA_WIDTH-1:0]  DATA_INIT   = '0,
  parameter int unsigned             VALID_PCT   = 50,
  parameter int unsigned             GAP_CYCLES  = 2,
  parameter int unsigned             SEED        = 1,
  parameter int unsigned             VERBOSE     = 0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start_in,
  input  logic [15:0]                pkt_len_in,
  input  logic [15:0]                num_pkts_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [TDATA_WIDTH-1:0]     tdata_m_out,
  output logic [TDATA_WIDTH/8-1:0]   tstrb_m_out,
  output logic [TDATA_WIDTH/8-1:0]   tkeep_m_out,
  output logic                       tlast_m_out,
  output logic [TID_WIDTH-1:0]       tid_m_out,
  output logic [TDEST_WIDTH-1:0]     tdest_m_out,
  output logic [TUSER_WIDTH-1:0]     tuser_m_out,
  output logic                       twakeup_m_out,
  output logic                       tvalid_m_out,
  input  logic                       tready_m_in
);

  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            num_q, num_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]            gap_cnt_q, gap_cnt_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   throttle_en;
  logic                   handshake;

  axis_throttle_gen #(
    .PCT  (VALID_PCT),
    .SEED (SEED)
  ) u_throttle (
    .clk    (aclk),
    .rst    (areset),
    .en_out (throttle_en)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    done_d     = 1'b0;
    handshake  = tvalid_q & tready_m_in;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (pkt_len_in == 16'd0 || num_pkts_in == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_SEND;
            len_d      = pkt_len_in;
            num_d      = num_pkts_in;
            beat_cnt_d = '0;
            pkt_cnt_d  = '0;
            gap_cnt_d  = '0;
            tdata_d    = DATA_INIT;
            tvalid_d   = 1'b0;
          end
        end
      end

      ST_SEND: begin
        if (!tvalid_q) begin
          tvalid_d = throttle_en;
        end else if (handshake) begin
          tdata_d = tdata_q + TDATA_WIDTH'(1);
          if (beat_cnt_q == len_q - 16'd1) begin
            beat_cnt_d = '0;
            if (pkt_cnt_q == num_q - 16'd1) begin
              tvalid_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              pkt_cnt_d = pkt_cnt_q + 16'd1;
              if (GAP_CYCLES == 0) begin
                tvalid_d = throttle_en;
              end else begin
                tvalid_d  = 1'b0;
                gap_cnt_d = '0;
                state_d   = ST_GAP;
              end
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
            tvalid_d   = throttle_en;
          end
        end
      end

      ST_GAP: begin
        // Leaving the gap evaluates the throttle directly so a full-rate run idles exactly GAP_CYCLES.
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_SEND;
          tvalid_d  = throttle_en;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    tlast_d = busy_d && (beat_cnt_d == len_d - 16'd1);
    tuser_d = TUSER_WIDTH'(pkt_cnt_d);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      num_q      <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign tdata_m_out   = tdata_q;
  assign tstrb_m_out   = '1;
  assign tkeep_m_out   = '1;
  assign tlast_m_out   = tlast_q;
  assign tid_m_out     = TID_WIDTH'(TID_VALUE);
  assign tdest_m_out   = TDEST_WIDTH'(TDEST_VALUE);
  assign tuser_m_out   = tuser_q;
  assign twakeup_m_out = busy_q;
  assign tvalid_m_out  = tvalid_q;

  // Debug builds check the AXIS hold rule on every stalled beat instead of printing beats.
  if (VERBOSE != 0) begin : g_verbose
    hold_a: assert property (@(posedge aclk) disable iff (areset)
      (tvalid_q && !tready_m_in) |=>
        (tvalid_q && $stable(tdata_q) && $stable(tlast_q) && $stable(tuser_q)));
  end

endmodule

// File: tb/tb_axi_stream_source.sv
// Directed bench for axi_stream_source: two instances (DATA_INIT 0 and 16'hFFFE),
// full-rate TVALID so beat timing is exact.
module tb_axi_stream_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Instance A: DATA_INIT = 0
  logic        areset, start, tready;
  logic [15:0] pkt_len, num_pkts;
  logic        busy, done, tlast, twakeup, tvalid;
  logic [15:0] tdata;
  logic [1:0]  tstrb, tkeep, tuser;
  logic        tid, tdest;

  // Instance B: DATA_INIT = 16'hFFFE
  logic        areset_b, start_b, tready_b;
  logic [15:0] pkt_len_b, num_pkts_b;
  logic        busy_b, done_b, tlast_b, twakeup_b, tvalid_b;
  logic [15:0] tdata_b;
  logic [1:0]  tstrb_b, tkeep_b, tuser_b;
  logic        tid_b, tdest_b;

  axi_stream_source #(
    .TDATA_WIDTH (16),
    .TUSER_WIDTH (2),
    .DATA_INIT   (16'h0000),
    .VALID_PCT   (100),
    .GAP_CYCLES  (2)
  ) u_dut (
    .aclk (clk), .areset (areset), .start_in (start),
    .pkt_len_in (pkt_len), .num_pkts_in (num_pkts),
    .busy_out (busy), .done_out (done),
    .tdata_m_out (tdata), .tstrb_m_out (tstrb), .tkeep_m_out (tkeep),
    .tlast_m_out (tlast), .tid_m_out (tid), .tdest_m_out (tdest),
    .tuser_m_out (tuser), .twakeup_m_out (twakeup),
    .tvalid_m_out (tvalid), .tready_m_in (tready)
  );

  axi_stream_source #(
    .TDATA_WIDTH (16),
    .TUSER_WIDTH (2),
    .DATA_INIT   (16'hFFFE),
    .VALID_PCT   (100),
    .GAP_CYCLES  (2)
  ) u_dut_b (
    .aclk (clk), .areset (areset_b), .start_in (start_b),
    .pkt_len_in (pkt_len_b), .num_pkts_in (num_pkts_b),
    .busy_out (busy_b), .done_out (done_b),
    .tdata_m_out (tdata_b), .tstrb_m_out (tstrb_b), .tkeep_m_out (tkeep_b),
    .tlast_m_out (tlast_b), .tid_m_out (tid_b), .tdest_m_out (tdest_b),
    .tuser_m_out (tuser_b), .twakeup_m_out (twakeup_b),
    .tvalid_m_out (tvalid_b), .tready_m_in (tready_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_run++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b expected 0", tvalid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_run++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b expected 0", tlast); end
    n_run++; if (tdata !== 16'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 0000", tdata); end
    n_run++; if (tuser !== 2'd0) begin n_fail++; $display("FAIL reset_tuser: got %0d expected 0", tuser); end
    n_run++; if (twakeup !== 1'b0) begin n_fail++; $display("FAIL reset_twakeup: got %0b expected 0", twakeup); end
    n_run++; if ({tstrb, tkeep} !== 4'b1111) begin n_fail++; $display("FAIL reset_strb_keep: got %b expected 1111", {tstrb, tkeep}); end
    n_run++; if ({tid, tdest} !== 2'b00) begin n_fail++; $display("FAIL reset_id_dest: got %b expected 00", {tid, tdest}); end
    n_run++; if ({tvalid_b, tdata_b} !== 17'h0) begin n_fail++; $display("FAIL reset_b: got %h expected 00000", {tvalid_b, tdata_b}); end
  endtask

  // len=4, num=1: beats at samples 1..4 carry 0..3, tlast on the fourth, done at sample 5.
  task automatic test_single();
    logic [15:0] dq[$];
    logic        lq[$];
    int          aq[$];
    int          done_cnt = 0;
    int          done_at  = -1;
    pkt_len = 16'd4; num_pkts = 16'd1; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    n_run++; if ({busy, twakeup, tvalid} !== 3'b110) begin n_fail++; $display("FAIL single_busy: got %b expected 110", {busy, twakeup, tvalid}); end
    for (int i = 0; i < 12; i++) begin
      if (tvalid && tready) begin dq.push_back(tdata); lq.push_back(tlast); aq.push_back(i); end
      if (done) begin done_cnt++; done_at = i; end
      cyc();
    end
    n_run++; if (dq.size() !== 4) begin n_fail++; $display("FAIL single_beats: got %0d expected 4", dq.size()); end
    for (int k = 0; k < dq.size() && k < 4; k++) begin
      n_run++;
      if (dq[k] !== 16'(k) || lq[k] !== (k == 3) || aq[k] !== k + 1) begin
        n_fail++;
        $display("FAIL single_beat%0d: got data=%h last=%0b at=%0d expected data=%h last=%0b at=%0d",
                 k, dq[k], lq[k], aq[k], 16'(k), (k == 3), k + 1);
      end
    end
    n_run++; if (done_cnt !== 1 || done_at !== 5) begin n_fail++; $display("FAIL single_done: got count=%0d at=%0d expected count=1 at=5", done_cnt, done_at); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%0b expected 0", busy); end
  endtask

  // len=3, num=3, gap 2: beat k at sample 1+k+2*(k/3), tuser = k/3, done at sample 14.
  task automatic test_multi();
    logic [15:0] dq[$];
    logic        lq[$];
    logic [1:0]  uq[$];
    int          aq[$];
    int          done_cnt = 0;
    int          done_at  = -1;
    pkt_len = 16'd3; num_pkts = 16'd3; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid && tready) begin dq.push_back(tdata); lq.push_back(tlast); uq.push_back(tuser); aq.push_back(i); end
      if (done) begin done_cnt++; done_at = i; end
      cyc();
    end
    n_run++; if (dq.size() !== 9) begin n_fail++; $display("FAIL multi_beats: got %0d expected 9", dq.size()); end
    for (int k = 0; k < dq.size() && k < 9; k++) begin
      n_run++;
      if (dq[k] !== 16'(k) || lq[k] !== (k % 3 == 2) || uq[k] !== 2'(k / 3) || aq[k] !== 1 + k + 2 * (k / 3)) begin
        n_fail++;
        $display("FAIL multi_beat%0d: got data=%h last=%0b user=%0d at=%0d expected data=%h last=%0b user=%0d at=%0d",
                 k, dq[k], lq[k], uq[k], aq[k], 16'(k), (k % 3 == 2), k / 3, 1 + k + 2 * (k / 3));
      end
    end
    n_run++; if (done_cnt !== 1 || done_at !== 14) begin n_fail++; $display("FAIL multi_done: got count=%0d at=%0d expected count=1 at=14", done_cnt, done_at); end
  endtask

  // len=1, num=2 with tready low for 5 cycles: first beat must hold, second follows the gap.
  task automatic test_backpressure();
    pkt_len = 16'd1; num_pkts = 16'd2; tready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if ({tvalid, tdata, tlast, tuser} !== {1'b1, 16'h0000, 1'b1, 2'd0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%0b data=%h last=%0b user=%0d expected valid=1 data=0000 last=1 user=0",
                 i, tvalid, tdata, tlast, tuser);
      end
      if (i < 4) cyc();
    end
    tready = 1'b1;
    cyc();
    n_run++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_gap1: got valid=%0b expected 0", tvalid); end
    cyc();
    n_run++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_gap2: got valid=%0b expected 0", tvalid); end
    cyc();
    n_run++;
    if ({tvalid, tdata, tlast, tuser} !== {1'b1, 16'h0001, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_second: got valid=%0b data=%h last=%0b user=%0d expected valid=1 data=0001 last=1 user=1",
               tvalid, tdata, tlast, tuser);
    end
    cyc();
    n_run++; if ({done, busy, tvalid} !== 3'b100) begin n_fail++; $display("FAIL bp_done: got %b expected 100", {done, busy, tvalid}); end
    cyc();
  endtask

  task automatic test_zero_len();
    pkt_len = 16'd0; num_pkts = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    n_run++; if ({done, busy, tvalid} !== 3'b100) begin n_fail++; $display("FAIL len0_done: got %b expected 100", {done, busy, tvalid}); end
    cyc();
    n_run++; if ({done, busy, tvalid} !== 3'b000) begin n_fail++; $display("FAIL len0_after: got %b expected 000", {done, busy, tvalid}); end
    pkt_len = 16'd3; num_pkts = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_run++; if ({done, busy, tvalid} !== 3'b100) begin n_fail++; $display("FAIL num0_done: got %b expected 100", {done, busy, tvalid}); end
    cyc();
  endtask

  // A second start mid-run with different config must not disturb the 3-beat run.
  task automatic test_start_busy();
    logic [15:0] dq[$];
    logic        lq[$];
    int          done_cnt = 0;
    pkt_len = 16'd3; num_pkts = 16'd1; tready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin start = 1'b1; pkt_len = 16'd7; num_pkts = 16'd4; end
      if (i == 3) start = 1'b0;
      if (tvalid && tready) begin dq.push_back(tdata); lq.push_back(tlast); end
      if (done) done_cnt++;
      cyc();
    end
    n_run++; if (dq.size() !== 3) begin n_fail++; $display("FAIL busy_start_beats: got %0d expected 3", dq.size()); end
    for (int k = 0; k < dq.size() && k < 3; k++) begin
      n_run++;
      if (dq[k] !== 16'(k) || lq[k] !== (k == 2)) begin
        n_fail++;
        $display("FAIL busy_start_beat%0d: got data=%h last=%0b expected data=%h last=%0b", k, dq[k], lq[k], 16'(k), (k == 2));
      end
    end
    n_run++; if (done_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: got count=%0d busy=%0b expected count=1 busy=0", done_cnt, busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] dq[$];
    logic        lq[$];
    logic [15:0] exp_d[4];
    exp_d[0] = 16'hFFFE; exp_d[1] = 16'hFFFF; exp_d[2] = 16'h0000; exp_d[3] = 16'h0001;
    pkt_len_b = 16'd4; num_pkts_b = 16'd1; tready_b = 1'b1; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tvalid_b && tready_b) begin dq.push_back(tdata_b); lq.push_back(tlast_b); end
      cyc();
    end
    n_run++; if (dq.size() !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 4", dq.size()); end
    for (int k = 0; k < dq.size() && k < 4; k++) begin
      n_run++;
      if (dq[k] !== exp_d[k] || lq[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got data=%h last=%0b expected data=%h last=%0b", k, dq[k], lq[k], exp_d[k], (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] dq[$];
    int          done_cnt = 0;
    pkt_len_b = 16'd4; num_pkts_b = 16'd2; tready_b = 1'b1; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    cyc();
    cyc();
    #2 areset_b = 1'b1;
    #1;
    n_run++;
    if ({tvalid_b, busy_b, tlast_b, tdata_b} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL midreset_now: got valid=%0b busy=%0b last=%0b data=%h expected 0 0 0 0000", tvalid_b, busy_b, tlast_b, tdata_b);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done_b) done_cnt++;
    end
    areset_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done_b || tvalid_b) done_cnt++;
    end
    n_run++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midreset_nodone: got %0d done/valid cycles expected 0", done_cnt); end
    pkt_len_b = 16'd2; num_pkts_b = 16'd1; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tvalid_b && tready_b) dq.push_back(tdata_b);
      if (done_b) done_cnt++;
      cyc();
    end
    n_run++;
    if (dq.size() !== 2 || dq[0] !== 16'hFFFE || dq[1] !== 16'hFFFF || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL midreset_restart: got beats=%0d first=%h second=%h done=%0d expected beats=2 FFFE FFFF done=1",
               dq.size(), (dq.size() > 0) ? dq[0] : 16'hxxxx, (dq.size() > 1) ? dq[1] : 16'hxxxx, done_cnt);
    end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; tready = 1'b1; pkt_len = '0; num_pkts = '0;
    areset_b = 1'b1; start_b = 1'b0; tready_b = 1'b1; pkt_len_b = '0; num_pkts_b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    areset = 1'b0;
    areset_b = 1'b0;
    cyc();
    test_single();
    test_multi();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
